// File: rtl/division_pkg.sv
// Shared types and constants for the reconstruct-dividend datapath (q*d + r).
package division_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_SENTINEL = '1;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] dividend;
        logic                 overflow;
        logic                 invalid;
    } division_result_t;

endpackage

// File: rtl/mul_shift_add_step.sv
// One shift-add multiplication step: conditionally accumulate the (pre-shifted)
// multiplicand on the multiplier LSB, then retire that multiplier bit.
module mul_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] accumulator_i,
    input  logic [2*WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic [2*WIDTH-1:0] accumulator_o,
    output logic [WIDTH-1:0]   multiplier_o
);

    always_comb begin
        accumulator_o = accumulator_i;
        if (multiplier_i[0]) begin
            accumulator_o = accumulator_i + multiplicand_i;
        end
        multiplier_o = multiplier_i >> 1;
    end

endmodule

// File: rtl/division_reconstruct.sv
// Rebuilds a dividend from quotient, divisor and remainder with a serial shift-add multiplier.
// Build option: DIVISION_RECONSTRUCT_EARLY_EXIT_EN ends CALC once the multiplier runs out of ones.
module division_reconstruct
    import division_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic             i_ready,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_payload_quotient,
    input  logic [WIDTH-1:0] i_payload_divisor,
    input  logic [WIDTH-1:0] i_payload_remainder,
    input  logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_payload_dividend,
    output logic             o_payload_overflow,
    output logic             o_payload_invalid
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e         stateQ, stateD;
    logic [2*WIDTH-1:0] accQ, accD;
    logic [2*WIDTH-1:0] mcandQ, mcandD;
    logic [WIDTH-1:0]   mplierQ, mplierD;
    logic               invalidQ, invalidD;
    logic [CW-1:0]      cntQ, cntD;

    logic [2*WIDTH-1:0] stepAcc;
    logic [WIDTH-1:0]   stepMplier;
    logic               lastStep;

    mul_shift_add_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .accumulator_i (accQ),
        .multiplicand_i(mcandQ),
        .multiplier_i  (mplierQ),
        .accumulator_o (stepAcc),
        .multiplier_o  (stepMplier)
    );

`ifdef DIVISION_RECONSTRUCT_EARLY_EXIT_EN
    assign lastStep = (cntQ == CW'(WIDTH - 1)) || (stepMplier == '0);
`else
    assign lastStep = (cntQ == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= IDLE;
            accQ     <= '0;
            mcandQ   <= '0;
            mplierQ  <= '0;
            invalidQ <= 1'b0;
            cntQ     <= '0;
        end else begin
            stateQ   <= stateD;
            accQ     <= accD;
            mcandQ   <= mcandD;
            mplierQ  <= mplierD;
            invalidQ <= invalidD;
            cntQ     <= cntD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        accD     = accQ;
        mcandD   = mcandQ;
        mplierD  = mplierQ;
        invalidD = invalidQ;
        cntD     = cntQ;
        unique case (stateQ)
            IDLE: begin
                if (i_valid) begin
                    accD     = {{WIDTH{1'b0}}, i_payload_remainder};
                    mcandD   = {{WIDTH{1'b0}}, i_payload_divisor};
                    mplierD  = i_payload_quotient;
                    invalidD = (i_payload_remainder >= i_payload_divisor);
                    cntD     = '0;
                    stateD   = CALC;
                    // A zero divisor bypasses the multiplier and reports the sentinel.
                    if (i_payload_divisor == '0) begin
                        accD     = {{WIDTH{1'b0}}, {WIDTH{DIV_ZERO_SENTINEL[0]}}};
                        mplierD  = '0;
                        invalidD = 1'b1;
                        stateD   = HOLD;
                    end
`ifdef DIVISION_RECONSTRUCT_EARLY_EXIT_EN
                    else if (i_payload_quotient == '0) begin
                        stateD = HOLD;
                    end
`endif
                end
            end
            CALC: begin
                accD    = stepAcc;
                mplierD = stepMplier;
                mcandD  = mcandQ << 1;
                cntD    = cntQ + CW'(1);
                if (lastStep) begin
                    stateD = HOLD;
                end
            end
            HOLD: begin
                if (o_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        i_ready            = (stateQ == IDLE);
        o_valid            = (stateQ == HOLD);
        o_payload_dividend = o_valid ? accQ[WIDTH-1:0] : '0;
        o_payload_overflow = o_valid & (|accQ[2*WIDTH-1:WIDTH]);
        o_payload_invalid  = o_valid & invalidQ;
    end

endmodule

// File: tb/tb_division_reconstruct.sv
// Scoreboard bench for division_reconstruct: expected results are queued at drive time
// and popped when o_valid appears; also covers latency, backpressure, throughput and reset abort.
module tb_division_reconstruct;
    import division_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clk;
    logic         reset;
    logic         i_ready;
    logic         i_valid;
    logic [W-1:0] i_payload_quotient;
    logic [W-1:0] i_payload_divisor;
    logic [W-1:0] i_payload_remainder;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_payload_dividend;
    logic         o_payload_overflow;
    logic         o_payload_invalid;

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int prevAccept = -1;
    bit prevWasFull = 1'b0;

    division_result_t expQ[$];
    int latQ[$];

    division_reconstruct #(
        .WIDTH(W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_ready            (i_ready),
        .i_valid            (i_valid),
        .i_payload_quotient (i_payload_quotient),
        .i_payload_divisor  (i_payload_divisor),
        .i_payload_remainder(i_payload_remainder),
        .o_ready            (o_ready),
        .o_valid            (o_valid),
        .o_payload_dividend (o_payload_dividend),
        .o_payload_overflow (o_payload_overflow),
        .o_payload_invalid  (o_payload_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: exact 2W-bit product plus remainder, with the divide-by-zero override.
    function automatic division_result_t modelResult(input logic [W-1:0] q, input logic [W-1:0] d,
                                                     input logic [W-1:0] r);
        division_result_t res;
        logic [2*W-1:0] full;
        full = {{W{1'b0}}, q} * {{W{1'b0}}, d} + {{W{1'b0}}, r};
        res.dividend = full[W-1:0];
        res.overflow = |full[2*W-1:W];
        res.invalid  = (d == '0) || (r >= d);
        if (d == '0) begin
            res.dividend = DIV_ZERO_SENTINEL;
            res.overflow = 1'b0;
        end
        return res;
    endfunction

    // Edges counted with the accept edge as number one.
    function automatic int modelLatency(input logic [W-1:0] q, input logic [W-1:0] d);
        int lat;
        lat = W + 1;
        if (d == '0) lat = 1;
`ifdef DIVISION_RECONSTRUCT_EARLY_EXIT_EN
        else if (q == '0) lat = 1;
        else begin
            for (int b = 0; b < W; b++) begin
                if (q[b]) lat = b + 2;
            end
        end
`endif
        return lat;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                                 input int holdCycles);
        division_result_t exp;
        int expLat;
        int lat;
        @(negedge clk);
        checkOutput("in_ready_idle", {63'd0, i_ready}, 64'd1);
        i_valid             = 1'b1;
        i_payload_quotient  = q;
        i_payload_divisor   = d;
        i_payload_remainder = r;
        o_ready             = (holdCycles == 0);
        expQ.push_back(modelResult(q, d, r));
        latQ.push_back(modelLatency(q, d));
        @(posedge clk);
        #1;
        if (prevWasFull && prevAccept >= 0) begin
            checkOutput("throughput", 64'(cycleCount - prevAccept), 64'(W + 2));
        end
        prevAccept = cycleCount;
        prevWasFull = (d != '0) && (holdCycles == 0);
        // Keep presenting junk while busy; none of it may be taken.
        i_payload_quotient  = $urandom;
        i_payload_divisor   = $urandom;
        i_payload_remainder = $urandom;
        lat = 1;
        while (!o_valid && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        i_valid = 1'b0;
        exp = expQ.pop_front();
        expLat = latQ.pop_front();
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("dividend", 64'(o_payload_dividend), 64'(exp.dividend));
        checkOutput("overflow", {63'd0, o_payload_overflow}, {63'd0, exp.overflow});
        checkOutput("invalid", {63'd0, o_payload_invalid}, {63'd0, exp.invalid});
        checkOutput("in_ready_hold", {63'd0, i_ready}, 64'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", {63'd0, o_valid}, 64'd1);
            checkOutput("bp_dividend", 64'(o_payload_dividend), 64'(exp.dividend));
            checkOutput("bp_in_ready", {63'd0, i_ready}, 64'd0);
        end
        if (holdCycles != 0) begin
            @(negedge clk);
            o_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("post_hs_ready", {63'd0, i_ready}, 64'd1);
        checkOutput("post_hs_valid", {63'd0, o_valid}, 64'd0);
    endtask

    initial begin
        reset               = 1'b0;
        i_valid             = 1'b0;
        i_payload_quotient  = '0;
        i_payload_divisor   = '0;
        i_payload_remainder = '0;
        o_ready             = 1'b0;
        #1;
        checkOutput("rst_in_ready", {63'd0, i_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("rst_dividend", 64'(o_payload_dividend), 64'd0);
        checkOutput("rst_overflow", {63'd0, o_payload_overflow}, 64'd0);
        checkOutput("rst_invalid", {63'd0, o_payload_invalid}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        applyStimulus(32'd3, 32'd5, 32'd2, 0);
        applyStimulus(32'd4, 32'd6, 32'd1, 0);
        applyStimulus(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 0);
        applyStimulus(32'hFFFF_FFFF, 32'd2, 32'd1, 0);
        applyStimulus(32'd1, 32'd4, 32'd4, 0);
        applyStimulus(32'd7, 32'd9, 32'd0, 10);
        applyStimulus(32'd0, 32'd13, 32'd5, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($urandom, $urandom, $urandom, k);
        end

        // Abort a transaction ten steps into CALC.
        @(negedge clk);
        i_valid             = 1'b1;
        i_payload_quotient  = 32'd123;
        i_payload_divisor   = 32'd456;
        i_payload_remainder = 32'd7;
        o_ready             = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_in_ready", {63'd0, i_ready}, 64'd1);
        checkOutput("abort_out_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("abort_dividend", 64'(o_payload_dividend), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        prevWasFull = 1'b0;
        applyStimulus(32'd2, 32'd3, 32'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/division_reconstruct.md
DIVISION_RECONSTRUCT -- requirements
Module: division_reconstruct

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset; asserting it (low) SHALL reset the block immediately.
REQ-004 Port i_ready, output, 1: the block SHALL assert it when it can accept an input transaction.
REQ-005 Port i_valid, input, 1: the input payload is valid.
REQ-006 Port i_payload_quotient, input, WIDTH: the quotient.
REQ-007 Port i_payload_divisor, input, WIDTH: the divisor.
REQ-008 Port i_payload_remainder, input, WIDTH: the remainder.
REQ-009 Port o_ready, input, 1: the downstream consumer can accept the output.
REQ-010 Port o_valid, output, 1: the block SHALL assert it when the output payload is valid.
REQ-011 Port o_payload_dividend, output, WIDTH: the reconstructed dividend, q*d+r (low WIDTH bits).
REQ-012 Port o_payload_overflow, output, 1: the exact result q*d+r exceeds 2^WIDTH-1.
REQ-013 Port o_payload_invalid, output, 1: the divisor is zero, or the remainder is greater than or equal to the divisor.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC and HOLD.
REQ-015 The block SHALL drive i_ready high only in IDLE and o_valid high only in HOLD.
REQ-016 An input transfer SHALL occur when i_valid and i_ready are both high on a rising clk edge.
REQ-017 On an input transfer with a nonzero divisor, the block SHALL do all of the following:
  - load a 2*WIDTH accumulator with the zero-extended remainder;
  - latch the quotient as the multiplier and the divisor as the multiplicand;
  - latch invalid = (remainder >= divisor);
  - go to CALC.
REQ-018 In CALC, each cycle SHALL perform one shift-add step:
  - if the multiplier LSB is 1, add the multiplicand (shifted by the iteration index) to the accumulator;
  - shift the multiplier right by one;
  - after exactly WIDTH steps, go to HOLD.
REQ-019 Latency SHALL be fixed: o_valid rises exactly WIDTH+1 rising edges after the accept edge (macro disabled).
REQ-020 In HOLD, the block SHALL drive:
  - o_payload_dividend = accumulator[WIDTH-1:0];
  - o_payload_overflow = OR of accumulator[2*WIDTH-1:WIDTH].
REQ-021 On an input transfer with divisor == 0, the block SHALL skip CALC and go directly to HOLD with:
  - dividend = all ones;
  - overflow = 0;
  - invalid = 1.
REQ-022 In HOLD, all payload outputs SHALL remain stable while o_ready is low, for any number of cycles.
REQ-023 When o_valid and o_ready are both high, the block SHALL go to IDLE.
REQ-024 i_ready SHALL rise on the cycle after the output handshake; an input SHALL NOT be accepted in the same cycle as the output handshake.
REQ-025 Any input change while the block is not in IDLE SHALL be ignored.
REQ-026 Sustained throughput SHALL be one transaction per WIDTH+2 cycles when o_ready is held high.

Reset
REQ-027 While reset is low, the block SHALL hold:
  - state = IDLE, so i_ready = 1 and o_valid = 0;
  - o_payload_dividend = 0, o_payload_overflow = 0, o_payload_invalid = 0;
  - accumulator and multiplier registers = 0.
REQ-028 Reset asserted in CALC or HOLD SHALL abort the transaction with no output handshake; the block SHALL accept a new input on the first edge after reset is released.

Configuration
REQ-029 The macro DIVISION_RECONSTRUCT_EARLY_EXIT_EN SHALL select the CALC termination rule.
REQ-030 With DIVISION_RECONSTRUCT_EARLY_EXIT_EN defined, CALC SHALL exit to HOLD as soon as the remaining multiplier is zero; latency is then variable, from 1 up to WIDTH+1 edges.
REQ-031 Without DIVISION_RECONSTRUCT_EARLY_EXIT_EN, CALC SHALL always run exactly WIDTH steps; results SHALL be identical in both builds.

Structure
REQ-032 The shared package division_pkg SHALL hold:
  - the WIDTH default;
  - the FSM state enum;
  - the divide-by-zero sentinel constant (all ones);
  - the result struct {dividend, overflow, invalid}.
REQ-033 The shift-add step SHALL be implemented in one combinational sub-module, mul_shift_add_step (inputs: accumulator, multiplicand, multiplier; outputs: next accumulator, next multiplier).

Verification
REQ-034 Basic case: q=3, d=5, r=2, o_ready=1 -> dividend=17, overflow=0, invalid=0, o_valid exactly WIDTH+1 edges after the accept edge.
REQ-035 Divide-by-zero: q=0xFFFFFFFF, d=0, r=0xFFFFFFFF -> o_valid on the next edge, dividend=0xFFFFFFFF, overflow=0, invalid=1.
REQ-036 Overflow: q=0xFFFFFFFF, d=2, r=1 -> dividend=0xFFFFFFFF, overflow=1, invalid=0.
REQ-037 Remainder too large: q=1, d=4, r=4 -> dividend=8, invalid=1.
REQ-038 Backpressure: q=7, d=9, r=0, o_ready held low for 10 cycles in HOLD -> payload stable at 63, i_ready=0 throughout; i_ready=1 on the cycle after the o_ready handshake.
REQ-039 Reset mid-CALC: assert reset at step 10 -> i_ready=1 and o_valid=0 immediately; a new transaction (q=2, d=3, r=1) then yields dividend=7.
